// File: rtl/mem_pkg.sv
// Shared definitions for the memory port arbiter.
//   state_t       : transaction FSM states (IDLE, WAIT, RESP)
//   WAIT_MAX      : largest supported WAIT_STATES value
//   CNT_W         : width of the wait-state counter
//   MAX_PORTS     : largest supported NPORTS value
//   onehot_to_idx : converts a one-hot port grant to a port index
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int WAIT_MAX  = 7;
  localparam int CNT_W     = $clog2(WAIT_MAX + 1);
  localparam int MAX_PORTS = 8;

  function automatic logic [2:0] onehot_to_idx(input logic [MAX_PORTS-1:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_PORTS; i++) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req        : request bits, one per port
//   last_grant : index of the most recently granted port
//   grant      : one-hot grant (all zero when no request), searching
//                upward from last_grant+1 with wrap-around
module rr_arbiter #(
  parameter int NPORTS = 2,
  parameter int LG_W   = (NPORTS > 1) ? $clog2(NPORTS) : 1
) (
  input  logic [NPORTS-1:0] req,
  input  logic [LG_W-1:0]   last_grant,
  output logic [NPORTS-1:0] grant
);

  always_comb begin : search
    int   p;
    logic found;
    // NOTE: every variable gets a default before any conditional assignment,
    // otherwise paths that skip the assignment infer a latch.
    grant = '0;
    found = 1'b0;
    p     = 0;
    // i = NPORTS visits last_grant itself last, so a lone requestor still wins.
    for (int i = 1; i <= NPORTS; i++) begin
      p = (int'(last_grant) + i) % NPORTS;
      if (!found && req[p]) begin
        grant[p] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Multi-port arbiter in front of a single-ported word memory.
//   clk, rst            : clock, asynchronous active-low reset
//   req_valid/req_ready : per-port request handshake
//   req_addr/wdata/be/we: per-port payload, port p in slice p of each bus
//   rsp_valid           : per-port one-cycle response strobe
//   rsp_rdata/rsp_err   : shared response data and error flag
//   busy                : a transaction is in flight
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int NPORTS      = 2,
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NPORTS-1:0]          req_valid,
  output logic [NPORTS-1:0]          req_ready,
  input  logic [NPORTS*ADDR_W-1:0]   req_addr,
  input  logic [NPORTS*DATA_W-1:0]   req_wdata,
  input  logic [NPORTS*DATA_W/8-1:0] req_be,
  input  logic [NPORTS-1:0]          req_we,
  output logic [NPORTS-1:0]          rsp_valid,
  output logic [DATA_W-1:0]          rsp_rdata,
  output logic                       rsp_err,
  output logic                       busy
);

  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = $clog2(BE_W);
  localparam int LG_W  = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(BE_W - 1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [LG_W-1:0]   last_grant;
  logic [LG_W-1:0]   lat_port;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [BE_W-1:0]   lat_be;
  logic              lat_we;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [NPORTS-1:0] grant;
  logic              handshake;
  logic [LG_W-1:0]   sel;
  logic [LG_W-1:0]   acc_port;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic [BE_W-1:0]   acc_be;
  logic              acc_we;
  logic [ADDR_W-1:0] word_idx;
  logic              acc_err;
  logic              access;

  rr_arbiter #(
    .NPORTS (NPORTS),
    .LG_W   (LG_W)
  ) u_rr (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (grant)
  );

  // Gated by rst so no port sees ready (and no handshake forms) during reset.
  assign req_ready = (state == IDLE && rst) ? grant : '0;
  assign handshake = |(req_valid & req_ready);
  assign sel       = LG_W'(onehot_to_idx(MAX_PORTS'(grant)));

  // With zero wait states the access happens on the acceptance edge itself,
  // so the payload comes straight from the granted port instead of the latch.
  always_comb begin
    if (state == IDLE) begin
      acc_port  = sel;
      acc_addr  = req_addr[sel*ADDR_W +: ADDR_W];
      acc_wdata = req_wdata[sel*DATA_W +: DATA_W];
      acc_be    = req_be[sel*BE_W +: BE_W];
      acc_we    = req_we[sel];
    end else begin
      acc_port  = lat_port;
      acc_addr  = lat_addr;
      acc_wdata = lat_wdata;
      acc_be    = lat_be;
      acc_we    = lat_we;
    end
    access   = (state == IDLE && handshake && WAIT_STATES == 0) ||
               (state == WAIT && cnt == '0);
    word_idx = acc_addr >> OFF_W;
    acc_err  = ((acc_addr & OFF_MASK) != '0) || (word_idx >= ADDR_W'(DEPTH));
  end

  // NOTE: the storage array has no reset; it maps onto plain RAM and its
  // contents are undefined until written.
  always_ff @(posedge clk) begin
    if (access && acc_we && !acc_err) begin
      for (int b = 0; b < BE_W; b++) begin
        if (acc_be[b]) mem[word_idx[IDX_W-1:0]][b*8 +: 8] <= acc_wdata[b*8 +: 8];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      last_grant <= LG_W'(NPORTS - 1);
      lat_port   <= '0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_be     <= '0;
      lat_we     <= 1'b0;
      rsp_valid  <= '0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      rsp_valid <= '0;
      if (access) begin
        rsp_valid <= NPORTS'(1) << acc_port;
        rsp_rdata <= (acc_we || acc_err) ? '0 : mem[word_idx[IDX_W-1:0]];
        rsp_err   <= acc_err;
      end
      unique case (state)
        IDLE: begin
          if (handshake) begin
            lat_port   <= sel;
            lat_addr   <= acc_addr;
            lat_wdata  <= acc_wdata;
            lat_be     <= acc_be;
            lat_we     <= acc_we;
            last_grant <= sel;
            busy       <= 1'b1;
            if (WAIT_STATES > 0) begin
              state <= WAIT;
              cnt   <= CNT_W'(WAIT_STATES - 1);
            end else begin
              state <= RESP;
            end
          end
        end
        WAIT: begin
          if (cnt == '0) state <= RESP;
          else           cnt   <= cnt - 1'b1;
        end
        RESP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- NPORTS, 2: requestor ports (instruction fetch, data, ...), range 1..8.
- DATA_W, 32: data width in bits, a multiple of 8.
- ADDR_W, 32: byte-address width.
- DEPTH, 1024: memory words.
- WAIT_STATES, 1: extra access cycles, range 0..7.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1: clock.
- rst, in, 1: reset, asynchronous, active-low.
- req_valid, in, NPORTS: request present, one bit per port.
- req_ready, out, NPORTS: request accepted this cycle.
- req_addr, in, NPORTS*ADDR_W: byte address per port.
- req_wdata, in, NPORTS*DATA_W: write data per port.
- req_be, in, NPORTS*DATA_W/8: byte enables per port.
- req_we, in, NPORTS: 1 = write, 0 = read.
- rsp_valid, out, NPORTS: one-cycle response strobe per port.
- rsp_rdata, out, DATA_W: read data, shared by all ports.
- rsp_err, out, 1: error flag, qualified by rsp_valid.
- busy, out, 1: a transaction is in flight.
REQ-003 Ports SHALL be packed with port p occupying slice p of each bus.

Function
REQ-004 The FSM SHALL have exactly three states: IDLE, WAIT, RESP.
REQ-005 In IDLE, the block SHALL raise req_ready for exactly one port: the first port with req_valid set, searching round-robin from last_grant+1.
REQ-006 A handshake (req_valid[p] & req_ready[p]) SHALL latch addr, wdata, be, we and p, and SHALL update last_grant to p.
REQ-007 After a handshake, the next state SHALL be WAIT with the counter loaded to WAIT_STATES-1 if WAIT_STATES>0; otherwise it SHALL be RESP.
REQ-008 WAIT SHALL decrement the counter and move to RESP on the edge where the counter equals 0.
REQ-009 The memory access SHALL occur on the edge entering RESP, and rsp_rdata/rsp_err SHALL be registered on that same edge.
REQ-010 In RESP, rsp_valid[p] SHALL be 1 for exactly one cycle, and the next state SHALL be IDLE.
REQ-011 rsp_valid SHALL assert WAIT_STATES+1 cycles after the acceptance edge; the next acceptance is possible in the cycle after RESP.
REQ-012 req_ready SHALL be 0 in WAIT and RESP; busy SHALL be 1 in WAIT and RESP.
REQ-013 A write SHALL update only the bytes whose req_be bit is 1; rsp_rdata SHALL be 0 for writes.
REQ-014 A read SHALL return the full word regardless of req_be.
REQ-015 A word index is addr >> log2(DATA_W/8).
REQ-016 A misaligned address (low log2(DATA_W/8) bits nonzero) or a word index >= DEPTH SHALL produce rsp_err=1 and rsp_rdata=0, with no memory change.
REQ-017 If all req_valid bits are 0 in IDLE, the block SHALL remain in IDLE and keep last_grant unchanged.
REQ-018 A requestor SHALL hold req_valid and its payload until its handshake; the block does not check this.
REQ-019 The memory array SHALL not be reset; its contents are undefined until written.

Reset
REQ-020 While rst=0, the block SHALL hold: state IDLE, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, counter=0.
REQ-021 While rst=0, last_grant SHALL be NPORTS-1, so that port 0 has first priority after reset.
REQ-022 Assertion of rst in WAIT SHALL abort the transaction with no memory write and no response; reset SHALL take effect asynchronously.
REQ-023 After rst deasserts, the block SHALL behave as freshly started.

Structure
REQ-024 The state enum (IDLE/WAIT/RESP) SHALL be defined in shared package mem_pkg.
REQ-025 The WAIT_STATES maximum (7) SHALL be defined in mem_pkg.
REQ-026 Round-robin selection SHALL be one sub-module, rr_arbiter, with inputs req and last_grant and a one-hot grant output.
REQ-027 rr_arbiter SHALL be purely combinational; the FSM and memory SHALL live in mem_port_arbiter.

Verification
REQ-028 WAIT_STATES=1: port 1 writes 0xDEADBEEF to addr 0x10 with be=0xF, then reads addr 0x10 -> rsp_valid[1] 2 cycles after each acceptance, read returns 0xDEADBEEF, rsp_err=0.
REQ-029 Write 0xAABBCCDD be=0xF, then 0x11223344 be=0x5, then read -> 0xAA22CC44.
REQ-030 Ports 0 and 1 hold req_valid continuously after reset -> grants alternate 0,1,0,1 and neither port waits more than one transaction.
REQ-031 Read addr 0x12 (misaligned) and addr DEPTH*4 -> rsp_err=1, rsp_rdata=0; a later read of addr 0x10 is unchanged.
REQ-032 WAIT_STATES=0 -> rsp_valid one cycle after acceptance, and acceptances occur every 2 cycles under continuous requests.
REQ-033 rst=0 asserted in WAIT during a write to 0x20 -> outputs zero immediately, no rsp_valid, 0x20 keeps its old value, port 0 is granted first after reset.
